// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with add, sub, add-with-carry, sub-with-borrow.
// Latency: 2 clk edges from acceptance to out_valid; one operation per cycle when out_ready is high.
// Backpressure: valid/ready; in_ready = !s1_valid || !out_valid || out_ready, forced low while rst is high.
// Optional macro CLA_PIPE_SAT_EN: saturate sum to signed max/min on signed overflow (cout/ovf untouched).
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    // Pipeline enables: a stage may load when it is empty or its content moves on.
    logic s1_valid;
    logic s2_en;
    logic s1_en;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && !rst;

    // Stage-1 operand conditioning: op[0] selects inversion of b, op[1] selects external carry.
    logic [WIDTH-1:0] b_eff;
    logic             c0_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    gp_in;
    logic [NG-1:0]    gg_in;

    assign b_eff  = op[0] ? ~b : b;
    assign c0_eff = op[1] ? cin : op[0];
    assign p_in   = a | b_eff;
    assign g_in   = a & b_eff;

    // 4-bit group propagate/generate from the bit-level p/g.
    always_comb begin
        gp_in = '0;
        gg_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = &p_in[4*k +: 4];
            gg_in[k] = g_in[4*k+3]
                     | (p_in[4*k+3] & g_in[4*k+2])
                     | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                     | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
        end
    end

    // Stage-1 registers.
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gp;
    logic [NG-1:0]    s1_gg;
    logic             s1_c0;

    // Stage 1: capture an accepted operation; bubbles propagate as s1_valid = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b_eff;
                s1_p  <= p_in;
                s1_g  <= g_in;
                s1_gp <= gp_in;
                s1_gg <= gg_in;
                s1_c0 <= c0_eff;
            end
        end
    end

    // Stage-2 carry resolution: group carries by lookahead, then bit carries inside each group.
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;
    logic             gc;
    logic             bc;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    always_comb begin
        grp_c = '0;
        gc    = s1_c0;
        for (int k = 0; k < NG; k++) begin
            grp_c[k] = gc;
            gc       = s1_gg[k] | (s1_gp[k] & gc);
        end
        grp_c[NG] = gc;

        bit_c = '0;
        bc    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % 4 == 0) begin
                bc = grp_c[i/4];
            end
            bit_c[i] = bc;
            bc       = s1_g[i] | (s1_p[i] & bc);
        end

        sum_raw  = s1_a ^ s1_b ^ bit_c;
        cout_nxt = grp_c[NG];
        ovf_nxt  = bit_c[WIDTH-1] ^ grp_c[NG];
`ifdef CLA_PIPE_SAT_EN
        if (ovf_nxt) begin
            sum_nxt = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_nxt = sum_raw;
        end
`else
        sum_nxt = sum_raw;
`endif
    end

    // Stage 2: output registers hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_nxt;
                cout <= cout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  upstream holds a valid operation.
REQ-005 SHALL have port in_ready  out  1  block accepts an operation this cycle.
REQ-006 SHALL have port a  in  WIDTH  operand A.
REQ-007 SHALL have port b  in  WIDTH  operand B.
REQ-008 SHALL have port cin  in  1  carry/borrow-in for ops 10 and 11.
REQ-009 SHALL have port op  in  2  operation: 00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow.
REQ-010 SHALL have port out_valid  out  1  result registers hold a valid result.
REQ-011 SHALL have port out_ready  in  1  downstream consumes the result this cycle.
REQ-012 SHALL have port sum  out  WIDTH  result.
REQ-013 SHALL have port cout  out  1  carry out of the MSB (subtraction: 1 = no borrow).
REQ-014 SHALL have port ovf  out  1  two's-complement signed overflow.

Function
REQ-015 SHALL form effective operand B' = b for ops 00/10 and B' = ~b for ops 01/11.
REQ-016 SHALL form effective carry-in: 0 for op 00, 1 for op 01, cin for ops 10/11.
REQ-017 SHALL compute {cout,sum} = a + B' + carry-in, modulo 2^(WIDTH+1).
REQ-018 SHALL compute ovf = carry into the MSB XOR carry out of the MSB.
REQ-019 Stage 1 SHALL register bit p = a|B' and g = a&B'; 4-bit group P/G; a, B', and the carry-in.
REQ-020 Stage 2 SHALL resolve the group carries by lookahead over the stage-1 group P/G, form sum = a^B'^carries, and register sum, cout and ovf.
REQ-021 SHALL have a latency of exactly 2 clk edges from acceptance (in_valid && in_ready) to out_valid, when not stalled.
REQ-022 SHALL define s2_en = !out_valid || out_ready and s1_en = !s1_valid || s2_en.
REQ-023 SHALL drive in_ready = s1_en; a combinational path from out_ready to in_ready is permitted.
REQ-024 SHALL sustain 1 operation per cycle while out_ready = 1.
REQ-025 SHALL hold sum, cout and ovf stable while out_valid && !out_ready; no result is lost or duplicated.
REQ-026 SHALL deliver results in acceptance order.
REQ-027 SHALL ignore inputs when in_valid = 0 or in_ready = 0.
REQ-028 SHALL clear out_valid on an s2_en edge when stage 1 is empty.
REQ-029 On simultaneous consume at the output and accept at the input, all stages SHALL advance in the same cycle.
REQ-030 SHALL cover WIDTH+1-bit wrap-around: all-ones + 1 gives sum 0 and cout 1.

Reset
REQ-031 rst = 1 at a clk edge SHALL clear s1_valid, out_valid, sum, cout, ovf and all stage-1 registers to 0, overriding any simultaneous handshake.
REQ-032 While rst = 1, in_ready SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight operations; none SHALL appear after reset.

Configuration
REQ-034 SHALL support macro CLA_PIPE_SAT_EN to select saturating or wrapping signed results.
REQ-035 With CLA_PIPE_SAT_EN defined and ovf = 1, sum SHALL be the signed max (0x7F..F) if a[MSB] = 0, else the signed min (0x80..0).
REQ-036 With CLA_PIPE_SAT_EN defined, cout and ovf SHALL be unchanged by saturation.
REQ-037 Without CLA_PIPE_SAT_EN, sum SHALL wrap (modular result); no saturation logic is present.

Verification (WIDTH=16)
REQ-038 SHALL check add wrap-around: op 00, a=0xFFFF, b=0x0001 -> two edges later sum=0x0000, cout=1, ovf=0.
REQ-039 SHALL check subtraction: op 01, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
REQ-040 SHALL check signed overflow: op 00, a=0x7FFF, b=0x0001 -> ovf=1; sum=0x8000 without the macro, 0x7FFF with CLA_PIPE_SAT_EN.
REQ-041 SHALL check carry chaining: op 10, a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0; then op 11, a=0x0000, b=0x0000, cin=0 -> sum=0xFFFF, cout=0.
REQ-042 SHALL check backpressure: out_ready=0 with 3 back-to-back ops -> in_ready drops after 2 accepts; results stay held; raising out_ready yields results in order, 1 per cycle.
REQ-043 SHALL check mid-operation reset: rst pulsed 1 cycle with 2 ops in flight -> out_valid=0 and outputs 0 the next cycle; no stale result afterwards.
